// File: rtl/ring_pkg.sv
// Shared ring definitions: slot type encoding and memory controller FSM states.
package ring_pkg;

  localparam int unsigned SLOT_TSIZE = 4;

  localparam int unsigned SLOT_EMPTY = 0;
  localparam int unsigned SLOT_ADDR  = 1;
  localparam int unsigned SLOT_WDATA = 2;
  localparam int unsigned SLOT_RDATA = 3;
  localparam int unsigned SLOT_INV   = 4;

  typedef enum logic [1:0] {
    s_idle  = 2'd0,
    s_read  = 2'd1,
    s_write = 2'd2
  } memctl_state_t;

endpackage

// File: rtl/ring_memctl_if.sv
// Word-level memory request bus between the ring memory controller and memory.
interface ring_memctl_if;

  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a push into a full FIFO succeeds only alongside a pop.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             push,
  input  logic [WIDTH-1:0]                 wdata,
  input  logic                             pop,
  output logic [WIDTH-1:0]                 rdata_c,
  output logic [$clog2(DEPTH+1)-1:0]       count,
  output logic                             overflow_c
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // Accept/reject decisions for this cycle
  always_comb begin
    do_pop     = pop && (count != '0);
    do_push    = push && ((count != CW'(DEPTH)) || do_pop);
    overflow_c = push && !do_push;
    rdata_c    = mem[rd_ptr];
  end

  // Pointer and occupancy tracking
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/ring_memctl.sv
// Ring memory controller: snoops ADDR/WDATA slots and runs line-sized word bursts.
module ring_memctl
  import ring_pkg::*;
#(
  parameter int unsigned TSIZE   = SLOT_TSIZE,
  parameter int unsigned NBWORDS = 3,
  parameter int unsigned RQDEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [TSIZE-1:0]     slot_type,
  input  logic [31:0]          slot_data,
  output logic                 mc_ack,
  output logic [NBWORDS-1:0]   mc_count,
  output logic [31:0]          mc_data,
  ring_memctl_if.master        mem,
  output logic                 err
);

  localparam int unsigned NWORDS = 1 << NBWORDS;
  localparam int unsigned LW     = 30 - NBWORDS;
  localparam int unsigned RQW    = LW + 1;
  localparam int unsigned DQD    = 2 * NWORDS;
  localparam int unsigned RCW    = $clog2(RQDEPTH + 1);
  localparam int unsigned DCW    = $clog2(DQD + 1);

  memctl_state_t      state, state_d;
  logic [NBWORDS-1:0] k, k_d;

  logic               rq_push, rq_pop, rq_ovf;
  logic [RQW-1:0]     rq_head;
  logic [RCW-1:0]     rq_count;
  logic               dq_push, dq_pop, dq_ovf;
  logic [31:0]        dq_head;
  logic [DCW-1:0]     dq_count;
  logic               short_wr;
  logic               busy;
  logic               rq_we;
  logic [LW-1:0]      rq_line;

  assign rq_push = (slot_type == TSIZE'(SLOT_ADDR));
  assign dq_push = (slot_type == TSIZE'(SLOT_WDATA));
  assign rq_we   = rq_head[LW];
  assign rq_line = rq_head[LW-1:0];
  assign busy    = (state != s_idle);

  sync_fifo #(.WIDTH(RQW), .DEPTH(RQDEPTH)) u_req_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (rq_push),
    .wdata      (slot_data[LW:0]),
    .pop        (rq_pop),
    .rdata_c    (rq_head),
    .count      (rq_count),
    .overflow_c (rq_ovf)
  );

  sync_fifo #(.WIDTH(32), .DEPTH(DQD)) u_data_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (dq_push),
    .wdata      (slot_data),
    .pop        (dq_pop),
    .rdata_c    (dq_head),
    .count      (dq_count),
    .overflow_c (dq_ovf)
  );

  // Dispatch, burst sequencing and FIFO pops
  always_comb begin
    state_d  = state;
    k_d      = k;
    rq_pop   = 1'b0;
    dq_pop   = 1'b0;
    short_wr = 1'b0;
    case (state)
      s_idle: begin
        if (rq_count != '0) begin
          if (!rq_we) begin
            state_d = s_read;
          end else if (dq_count >= DCW'(NWORDS)) begin
            state_d = s_write;
          end else begin
            short_wr = 1'b1;
            rq_pop   = 1'b1;
          end
        end
      end
      s_read, s_write: begin
        if (mem.mem_ack) begin
          k_d    = k + NBWORDS'(1);
          dq_pop = (state == s_write);
          if (k == NBWORDS'(NWORDS - 1)) begin
            state_d = s_idle;
            rq_pop  = 1'b1;
          end
        end
      end
      default: state_d = s_idle;
    endcase
  end

  // State and word counter registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= s_idle;
      k     <= '0;
    end else begin
      state <= state_d;
      k     <= k_d;
    end
  end

  // Registered read return and sticky error
  always_ff @(posedge clk) begin
    if (!reset) begin
      mc_ack   <= 1'b0;
      mc_count <= '0;
      mc_data  <= '0;
      err      <= 1'b0;
    end else begin
      mc_ack <= (state == s_read) && mem.mem_ack;
      if ((state == s_read) && mem.mem_ack) begin
        mc_count <= k;
        mc_data  <= mem.mem_rdata;
      end
      err <= err | rq_ovf | dq_ovf | short_wr;
    end
  end

  // Request outputs decode from registered state; data FIFO head only moves on ack
  assign mem.mem_req   = busy;
  assign mem.mem_we    = (state == s_write);
  assign mem.mem_addr  = busy ? {rq_line, k} : '0;
  assign mem.mem_wdata = (state == s_write) ? dq_head : '0;

endmodule

// File: doc/ring_memctl.md
RING_MEMCTL -- requirements
Module: ring_memctl

Interface
REQ-001 SHALL have parameter TSIZE, default 4, slot type field width.
REQ-002 SHALL have parameter NBWORDS, default 3, log2 of words per cache line (NWORDS = 2^NBWORDS).
REQ-003 SHALL have parameter RQDEPTH, default 4, request FIFO depth in entries.
REQ-004 SHALL have ports: clk  in  1  sole clock; reset  in  1  synchronous, active-low reset.
REQ-005 SHALL have ports: slot_type  in  TSIZE  ring slot type seen this cycle; slot_data  in  32  ring slot payload.
REQ-006 SHALL have ports: mc_ack  out  1  one returned read word valid; mc_count  out  NBWORDS  word index within line; mc_data  out  32  returned word.
REQ-007 SHALL have ports: mem_req  out  1  memory word request; mem_we  out  1  write when 1; mem_addr  out  30  word address [31:2]; mem_wdata  out  32; mem_ack  in  1  request done; mem_rdata  in  32  read data, valid with mem_ack.
REQ-008 SHALL have ports: err  out  1  sticky protocol/overflow error.

Function
REQ-009 SHALL snoop every cycle; slot types other than ADDR and WDATA are ignored.
REQ-010 SHALL push slot_data into a data FIFO of depth 2*NWORDS on each WDATA slot.
REQ-011 SHALL push each ADDR slot into the request FIFO: line = slot_data[29-NBWORDS:0] (addr[31:NBWORDS+2]), write flag = slot_data[30-NBWORDS]; slot_data[31-NBWORDS] (cache type) is ignored.
REQ-012 SHALL accept a push into a full FIFO only when a pop occurs in the same cycle; otherwise drop the push and set err.
REQ-013 SHALL implement FSM states s_idle, s_read, s_write; the idle FSM dispatches the request FIFO head on the next cycle after it becomes non-empty.
REQ-014 SHALL, on dispatching a write request with fewer than NWORDS entries in the data FIFO, drop the request, set err, and remain in s_idle.
REQ-015 SHALL in s_read/s_write drive mem_req=1, mem_addr={line,k}, with word counter k starting at 0; keep one request outstanding, holding the outputs stable until mem_ack.
REQ-016 SHALL in s_write drive mem_we=1 and mem_wdata=data FIFO head; pop the data FIFO on each mem_ack.
REQ-017 SHALL in s_read, on mem_ack, register mc_ack=1, mc_count=k, mc_data=mem_rdata for exactly the following cycle; mc_ack=0 otherwise.
REQ-018 SHALL increment k on each mem_ack; on mem_ack with k==NWORDS-1 return to s_idle and pop the request FIFO; k wraps to 0.
REQ-019 SHALL deliver read words strictly in order 0..NWORDS-1, with gaps allowed between words.
REQ-020 SHALL allow a new dispatch in the cycle after returning to s_idle; minimum mem_req-to-mc_ack latency is 1 cycle after mem_ack.
REQ-021 SHALL keep snooping and pushing during any state, including the same cycle as a pop.
REQ-022 SHALL hold err at 1 until reset.

Reset
REQ-023 SHALL, when reset=0 at a clk edge, go to s_idle, empty both FIFOs, clear k, and drive mc_ack, mem_req, mem_we, and err to 0; mc_count, mc_data, mem_addr, and mem_wdata are 0.
REQ-024 SHALL abandon any in-flight burst on reset mid-operation; a late mem_ack after reset is ignored.

Structure
REQ-025 SHALL take slot type constants (ADDR, WDATA, ...) and TSIZE from a shared ring_pkg package that is also used by cache.
REQ-026 SHALL instantiate one parameterized sub-module, sync_fifo (WIDTH, DEPTH), twice: request FIFO (line + write flag) and data FIFO (32 bits).

Verification
REQ-027 Read: ADDR slot_data=0x0000_1234 (flag 0), mem_ack one cycle after each mem_req -> mem_addr 0x91A0..0x91A7, eight mc_ack pulses with mc_count 0..7 and mc_data=mem_rdata.
REQ-028 Write: 8 WDATA 0xA0..0xA7 then ADDR with flag=1, line 0x55 -> eight mem_we requests at addr 0x2A8..0x2AF with data 0xA0..0xA7; no mc_ack.
REQ-029 Back-to-back: write line then read same line queued while the write is busy -> the read is issued only after the last write mem_ack; order preserved.
REQ-030 Overflow: 5 ADDR slots while mem_ack is held low, RQDEPTH=4 -> 5th dropped, err=1; first 4 serviced in order.
REQ-031 Short write: 3 WDATA then write ADDR -> request dropped, err=1, no mem_req.
REQ-032 Reset mid-read after 3 words -> mem_req=0 the next cycle, FIFOs empty, a subsequent read returns all 8 words from count 0.
